// File: rtl/prog_timer_array.sv
// Bank of programmable down-counter timers on a 4-bit peripheral bus.
// One shared 11-bit prescaler feeds tap ticks to every channel; each channel
// picks a prescaler tap, its own synchronised external input, or the previous
// channel's underflow as its tick source.

module prog_timer_ch #(
  parameter int W   = 8,
  parameter int NIB = W / 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tap,
  input  logic       ext_tick,
  input  logic       casc_in,
  input  logic       wr,
  input  logic       rd,
  input  logic [3:0] off,
  input  logic [3:0] wdata,
  output logic [3:0] rdata,
  output logic       irq,
  output logic       underflow
);
  // Snapshot only needs the nibbles above nibble 0.
  localparam int SW = (W > 4) ? W - 4 : 4;

  logic [W-1:0]  cnt_q, cnt_d, rld_q, rld_d;
  logic [SW-1:0] snap_q, snap_d;
  logic          en_q, en_d, os_q, os_d, mask_q, mask_d;
  logic          fac_q, fac_d, uf_q, uf_d, irq_q, irq_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    sync_q, sync_d;  // [0],[1] synchroniser, [2] previous value for edge detect
  logic          tick, strobe;

  // Tick source select: external edge, cascade, or prescaler tap.
  always_comb begin
    case (sel_q)
      3'd0:    tick = sync_q[1] & ~sync_q[2];
      3'd1:    tick = casc_in;
      default: tick = tap[sel_q];
    endcase
  end

  // Next state: bus writes/read side effects, then strobe or tick processing.
  always_comb begin
    cnt_d  = cnt_q;
    rld_d  = rld_q;
    snap_d = snap_q;
    en_d   = en_q;
    os_d   = os_q;
    sel_d  = sel_q;
    mask_d = mask_q;
    fac_d  = fac_q;
    uf_d   = 1'b0;
    irq_d  = fac_q & mask_q;
    sync_d = {sync_q[1:0], ext_tick};
    strobe = 1'b0;
    if (wr) begin
      for (int i = 0; i < NIB; i++)
        if (off == 4'(4 + i)) rld_d[i*4 +: 4] = wdata;
      case (off)
        4'h8: begin en_d = wdata[0]; strobe = wdata[1]; os_d = wdata[2]; end
        4'h9: sel_d  = wdata[2:0];
        4'hA: mask_d = wdata[0];
        default: ;
      endcase
    end
    if (rd && off == 4'h0) snap_d = SW'(cnt_q >> 4);
    // Clear first so a same-cycle underflow below wins.
    if (rd && off == 4'hB) fac_d = 1'b0;
    if (strobe) begin
      cnt_d = rld_q;
    end else if (tick && en_q) begin
      if (cnt_q == W'(1)) begin
        uf_d  = 1'b1;
        fac_d = 1'b1;
        if (os_q) begin
          cnt_d = '0;
          en_d  = 1'b0;
        end else begin
          cnt_d = rld_q;
        end
      end else begin
        cnt_d = cnt_q - W'(1);  // 0 wraps to all-ones
      end
    end
  end

  // Register map read mux, combinational from offset.
  always_comb begin
    rdata = 4'h0;
    case (off)
      4'h0: rdata = cnt_q[3:0];
      4'h8: rdata = {1'b0, os_q, 1'b0, en_q};
      4'h9: rdata = {1'b0, sel_q};
      4'hA: rdata = {3'b0, mask_q};
      4'hB: rdata = {3'b0, fac_q};
      default: ;
    endcase
    for (int i = 1; i < NIB; i++)
      if (off == 4'(i)) rdata = snap_q[(i-1)*4 +: 4];
    for (int i = 0; i < NIB; i++)
      if (off == 4'(4 + i)) rdata = rld_q[i*4 +: 4];
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      rld_q  <= '0;
      snap_q <= '0;
      en_q   <= 1'b0;
      os_q   <= 1'b0;
      sel_q  <= 3'd0;
      mask_q <= 1'b0;
      fac_q  <= 1'b0;
      uf_q   <= 1'b0;
      irq_q  <= 1'b0;
      sync_q <= 3'd0;
    end else begin
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      snap_q <= snap_d;
      en_q   <= en_d;
      os_q   <= os_d;
      sel_q  <= sel_d;
      mask_q <= mask_d;
      fac_q  <= fac_d;
      uf_q   <= uf_d;
      irq_q  <= irq_d;
      sync_q <= sync_d;
    end
  end

  assign irq       = irq_q;
  assign underflow = uf_q;
endmodule

module prog_timer_array #(
  parameter  int CHANNELS      = 2,
  parameter  int COUNTER_WIDTH = 8,
  localparam int NIBBLES       = COUNTER_WIDTH / 4,
  localparam int AW            = $clog2(CHANNELS) + 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk_en,
  input  logic [CHANNELS-1:0] ext_tick,
  input  logic [AW-1:0]       bus_addr,
  input  logic                bus_wr,
  input  logic                bus_rd,
  input  logic [3:0]          bus_wdata,
  output logic [3:0]          bus_rdata,
  output logic [CHANNELS-1:0] irq,
  output logic [CHANNELS-1:0] underflow
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [10:0]               pre_q, pre_d;
  logic [7:0]                tap;
  logic [CW-1:0]             ch_sel;
  logic [CHANNELS-1:0]       casc;
  logic [CHANNELS-1:0][3:0]  ch_rdata;

  // Prescaler and tap ticks: tap s fires when the increment clears bits [10-s:0].
  always_comb begin
    pre_d = clk_en ? pre_q + 11'd1 : pre_q;
    tap   = 8'h00;
    for (int s = 2; s < 8; s++)
      tap[s] = clk_en && ((pre_d & 11'((1 << (11 - s)) - 1)) == 11'd0);
  end

  // Free-running prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_q <= 11'd0;
    else          pre_q <= pre_d;
  end

  if (CHANNELS > 1) begin : g_dec
    assign ch_sel = bus_addr[AW-1:4];
  end else begin : g_dec1
    assign ch_sel = 1'b0;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    if (g == 0) begin : g_c0
      assign casc[g] = 1'b0;
    end else begin : g_cn
      assign casc[g] = underflow[g-1];
    end

    prog_timer_ch #(.W(COUNTER_WIDTH), .NIB(NIBBLES)) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tap       (tap),
      .ext_tick  (ext_tick[g]),
      .casc_in   (casc[g]),
      .wr        (bus_wr && (ch_sel == CW'(g))),
      .rd        (bus_rd && (ch_sel == CW'(g))),
      .off       (bus_addr[3:0]),
      .wdata     (bus_wdata),
      .rdata     (ch_rdata[g]),
      .irq       (irq[g]),
      .underflow (underflow[g])
    );
  end

  // Channel read mux; channel indices with no instance read 0.
  always_comb begin
    bus_rdata = 4'h0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch_sel == CW'(i)) bus_rdata = ch_rdata[i];
  end
endmodule
